// File: rtl/hdr_pkg.sv
// hdr_pkg: shared pixel width and line-pairing FSM states for the HDR front end.
package hdr_pkg;
  localparam int HDR_PIX_W = 10;
  typedef enum logic [2:0] {IDLE, WR_EVEN, WAIT_ODD, RD_ODD, WAIT_EVEN} state_e;
endpackage

// File: rtl/hdr_line_ram.sv
// hdr_line_ram: simple dual-port line buffer, one write port and one registered read port.
module hdr_line_ram #(
  parameter int W     = 10,
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/hdr_line_pairer.sv
// hdr_line_pairer: buffers each even (short) line and emits it paired pixel-by-pixel with
// the following odd (long) line.
module hdr_line_pairer
  import hdr_pkg::*;
#(
  parameter int DATA_WIDTH = HDR_PIX_W,
  parameter int MAX_PIX    = 2048,
  parameter int ADDR_W     = $clog2(MAX_PIX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pix_i,
  input  logic                  valid_i,
  input  logic                  sof_i,
  input  logic                  eol_i,
  output logic [DATA_WIDTH-1:0] data_o0,
  output logic [DATA_WIDTH-1:0] data_o1,
  output logic                  valid_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  len_err_o
);
  // one extra bit so the column can saturate at MAX_PIX itself
  localparam int CW = ADDR_W + 1;
  state_e                state_q;
  logic [CW-1:0]         col_q, len_q, col_d;
  logic                  first_q;
  logic                  p_valid_q, p_eol_q, p_inr_q, p_first_q;
  logic [DATA_WIDTH-1:0] p_pix_q, ram_q;
  logic                  sof, is_even, is_odd, col_sat, we, re;
  logic [ADDR_W-1:0]     waddr;
  always_comb begin
    sof     = valid_i & sof_i;
    is_even = valid_i & ~sof_i & (state_q == WR_EVEN || state_q == WAIT_EVEN);
    is_odd  = valid_i & ~sof_i & (state_q == WAIT_ODD || state_q == RD_ODD);
    col_sat = col_q >= CW'(MAX_PIX);
    col_d   = col_sat ? col_q : col_q + CW'(1);
    we      = sof | (is_even & ~col_sat);
    re      = is_odd & ~col_sat;
    waddr   = sof ? '0 : col_q[ADDR_W-1:0];
  end
  hdr_line_ram #(.W(DATA_WIDTH), .DEPTH(MAX_PIX), .AW(ADDR_W)) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(pix_i),
    .re_i   (re),
    .raddr_i(col_q[ADDR_W-1:0]),
    .rdata_o(ram_q)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      len_q     <= '0;
      first_q   <= 1'b0;
      p_valid_q <= 1'b0;
      p_eol_q   <= 1'b0;
      p_inr_q   <= 1'b0;
      p_first_q <= 1'b0;
      p_pix_q   <= '0;
      data_o0   <= '0;
      data_o1   <= '0;
      valid_o   <= 1'b0;
      sof_o     <= 1'b0;
      eol_o     <= 1'b0;
      len_err_o <= 1'b0;
    end else begin
      p_valid_q <= is_odd;
      p_eol_q   <= eol_i;
      p_pix_q   <= pix_i;
      p_inr_q   <= col_q < len_q;
      p_first_q <= first_q;
      valid_o   <= p_valid_q;
      sof_o     <= p_valid_q & p_first_q;
      eol_o     <= p_valid_q & p_eol_q;
      if (p_valid_q) begin
        data_o0 <= p_inr_q ? ram_q : '0;
        data_o1 <= p_pix_q;
      end
      if (sof) begin
        first_q   <= 1'b1;
        len_err_o <= 1'b0;
        col_q     <= eol_i ? '0 : CW'(1);
        if (eol_i) len_q <= CW'(1);
        state_q   <= eol_i ? WAIT_ODD : WR_EVEN;
      end else if (is_even) begin
        if (col_sat) len_err_o <= 1'b1;
        if (eol_i) len_q <= col_d;
        col_q   <= eol_i ? '0 : col_d;
        state_q <= eol_i ? WAIT_ODD : WR_EVEN;
      end else if (is_odd) begin
        first_q <= 1'b0;
        if (col_q >= len_q || (eol_i && col_d < len_q)) len_err_o <= 1'b1;
        col_q   <= eol_i ? '0 : col_d;
        state_q <= eol_i ? WAIT_EVEN : RD_ODD;
      end
    end
  end
endmodule

// File: tb/tb_hdr_line_pairer.sv
// tb_hdr_line_pairer: directed and randomized line sequences checked cycle by cycle
// against a line-level reference model.
module tb_hdr_line_pairer;
  localparam int W = 10;
  localparam int MAXP = 16;
  logic clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0, sof_i = 1'b0, eol_i = 1'b0;
  logic [W-1:0] pix_i = '0;
  logic [W-1:0] data_o0, data_o1;
  logic valid_o, sof_o, eol_o, len_err_o;
  int passed = 0, total = 0;
  bit in_frame, odd_line, first, m_err;
  int col, even_len;
  int store [MAXP];
  bit pv, pf, pe;
  int p0, p1;
  int ev, es, ee, e0, e1;

  always #5 clk = ~clk;

  hdr_line_pairer #(.DATA_WIDTH(W), .MAX_PIX(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .pix_i(pix_i), .valid_i(valid_i), .sof_i(sof_i),
    .eol_i(eol_i), .data_o0(data_o0), .data_o1(data_o1), .valid_o(valid_o),
    .sof_o(sof_o), .eol_o(eol_o), .len_err_o(len_err_o)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_step(bit rst, bit v, bit s, bit e, int pix);
    if (rst) begin
      {ev, es, ee, e0, e1} = '0;
      {pv, in_frame, first, m_err, odd_line} = '0;
      col = 0;
      return;
    end
    ev = int'(pv);
    es = int'(pv & pf);
    ee = int'(pv & pe);
    if (pv) begin
      e0 = p0;
      e1 = p1;
    end
    pv = 1'b0;
    if (!v) return;
    if (s) begin
      in_frame = 1'b1;
      first = 1'b1;
      m_err = 1'b0;
      store[0] = pix;
      col = e ? 0 : 1;
      odd_line = e;
      if (e) even_len = 1;
    end else if (in_frame && !odd_line) begin
      if (col < MAXP) store[col] = pix;
      else m_err = 1'b1;
      col++;
      if (e) begin
        even_len = col < MAXP ? col : MAXP;
        odd_line = 1'b1;
        col = 0;
      end
    end else if (in_frame) begin
      pv = 1'b1;
      p0 = col < even_len ? store[col] : 0;
      p1 = pix;
      pf = first;
      pe = e;
      first = 1'b0;
      if (col >= even_len) m_err = 1'b1;
      col++;
      if (e) begin
        if (col < even_len) m_err = 1'b1;
        odd_line = 1'b0;
        col = 0;
      end
    end
  endtask

  task automatic cyc(bit v, bit s, bit e, int pix, bit rst = 1'b0);
    rst_n = ~rst;
    valid_i = v;
    sof_i = s;
    eol_i = e;
    pix_i = pix[W-1:0];
    @(posedge clk);
    model_step(rst, v, s, e, pix & 32'h3ff);
    #1;
    chk("valid_o", 32'(valid_o), ev);
    chk("sof_o", 32'(sof_o), es);
    chk("eol_o", 32'(eol_o), ee);
    chk("data_o0", 32'(data_o0), e0);
    chk("data_o1", 32'(data_o1), e1);
    chk("len_err_o", 32'(len_err_o), 32'(m_err));
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic line(int base, int len, bit s, int gap, bit rnd = 1'b0, bit term = 1'b1);
    for (int i = 0; i < len; i++) begin
      if (gap > 0) idle($urandom_range(0, gap));
      cyc(1'b1, s && i == 0, term && i == len - 1,
          rnd ? int'($urandom_range(0, 1023)) : base + i);
    end
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(2);
    // basic pairing
    line(0, 8, 1'b1, 0);
    line(100, 8, 1'b0, 0);
    idle(3);
    // random gaps inside and between lines
    line(0, 8, 1'b1, 3);
    idle($urandom_range(0, 5));
    line(100, 8, 1'b0, 3);
    idle(3);
    // short odd line
    line(10, 8, 1'b1, 0);
    line(200, 5, 1'b0, 0);
    idle(3);
    chk("short_odd_err", 32'(len_err_o), 1);
    // long odd line, sof clears the sticky error
    line(20, 4, 1'b1, 1);
    line(300, 6, 1'b0, 0);
    idle(3);
    chk("long_odd_err", 32'(len_err_o), 1);
    // restart in the middle of an odd line
    line(30, 8, 1'b1, 0);
    line(400, 3, 1'b0, 0, 1'b0, 1'b0);
    line(50, 6, 1'b1, 0);
    line(500, 6, 1'b0, 0);
    idle(3);
    chk("restart_err", 32'(len_err_o), 0);
    // reset mid even line, lines without sof ignored
    line(60, 3, 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 99, 1'b1);
    line(70, 4, 1'b0, 0);
    line(600, 4, 1'b0, 0);
    idle(2);
    line(80, 4, 1'b1, 0);
    line(700, 4, 1'b0, 0);
    idle(3);
    // even line longer than the line RAM
    line(0, MAXP + 2, 1'b1, 0);
    line(800, MAXP, 1'b0, 0);
    idle(3);
    chk("overflow_err", 32'(len_err_o), 1);
    // one-pixel line with sof and eol together, then a following line pair
    line(5, 1, 1'b1, 0);
    line(900, 1, 1'b0, 0);
    idle(2);
    line(6, 3, 1'b0, 1);
    line(910, 3, 1'b0, 1);
    idle(3);
    // randomized frames
    repeat (25) begin
      int elen, olen, npairs;
      npairs = $urandom_range(1, 3);
      for (int k = 0; k < npairs; k++) begin
        elen = $urandom_range(1, MAXP);
        olen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAXP)) : elen;
        line(0, elen, k == 0, 2, 1'b1);
        idle($urandom_range(0, 3));
        line(0, olen, 1'b0, 2, 1'b1);
        idle($urandom_range(0, 3));
      end
    end
    idle(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
